// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with a selectable read mode (registered
// or first-word-fall-through), fill level, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
// A write into a full FIFO is accepted when it is paired with an accepted read.
module sync_fifo_flex #(
   parameter int data_width      = 32,
   parameter int fifo_depth      = 8,
   parameter int almost_full_th  = 6,
   parameter int almost_empty_th = 2,
   parameter int fwft_mode       = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cs,
   input  logic                          wr_en,
   input  logic                          rd_en,
   input  logic                          flush,
   input  logic                          clr_err,
   input  logic [data_width-1:0]         data_in,
   output logic [data_width-1:0]         data_out,
   output logic                          empty,
   output logic                          full,
   output logic                          almost_empty,
   output logic                          almost_full,
   output logic [$clog2(fifo_depth):0]   level,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int AW = $clog2(fifo_depth);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] AF_TH = LW'(almost_full_th);
   localparam logic [LW-1:0] AE_TH = LW'(almost_empty_th);

   // The pointers carry one extra wrap bit so that full and empty are distinct.
   logic [LW-1:0]         wr_ptr, rd_ptr;
   logic [AW-1:0]         wr_idx, rd_idx;
   logic [data_width-1:0] mem [fifo_depth];

   logic flush_ok, rd_ok, wr_ok, ovf_set, unf_set;

   assign wr_idx = wr_ptr[AW-1:0];
   assign rd_idx = rd_ptr[AW-1:0];

   // Status is derived combinationally from the registered pointers only.
   assign level        = wr_ptr - rd_ptr;
   assign empty        = (wr_ptr == rd_ptr);
   assign full         = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
   assign almost_full  = (level >= AF_TH);
   assign almost_empty = (level <= AE_TH);

   // Flush wins over any read/write in the same cycle; those are neither
   // performed nor counted as errors.
   assign flush_ok = cs & flush;
   assign rd_ok    = cs & rd_en & ~empty & ~flush_ok;
   assign wr_ok    = cs & wr_en & (~full | rd_ok) & ~flush_ok;
   assign ovf_set  = cs & wr_en & full & ~rd_ok & ~flush_ok;
   assign unf_set  = cs & rd_en & empty & ~flush_ok;

   // Pointer update: flush returns both pointers to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush_ok) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + LW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + LW'(1);
      end
   end

   // Storage array; contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_idx] <= data_in;
   end

   // Sticky error flags; a set event in the same cycle beats clr_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_set)           overflow  <= 1'b1;
         else if (cs & clr_err) overflow  <= 1'b0;
         if (unf_set)           underflow <= 1'b1;
         else if (cs & clr_err) underflow <= 1'b0;
      end
   end

   generate
      if (fwft_mode != 0) begin : g_fwft
         // Head word shown directly; forced to zero while empty so the output
         // is clean after reset even though the memory is not.
         always_comb begin
            data_out = '0;
            if (!empty) data_out = mem[rd_idx];
         end
      end else begin : g_reg
         // Registered read: the old head is captured on the read edge, so a
         // paired write into the same slot cannot corrupt it.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)        data_out <= '0;
            else if (rd_ok) data_out <= mem[rd_idx];
         end
      end
   endgenerate

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised successor to the team's basic synchronous FIFO. It adds:
- selectable first-word-fall-through (FWFT) read mode
- fill-level output
- programmable almost-full / almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush
- accepted write while full, when paired with an accepted read

Single clock domain. Used as the general buffering stage between datapath producers and consumers.

Parameters:
data_width, 32, width of each stored word (>=1)
fifo_depth, 8, number of entries; power of two, >=2
almost_full_th, 6, almost_full asserts when level >= this value (1..fifo_depth)
almost_empty_th, 2, almost_empty asserts when level <= this value (0..fifo_depth-1)
fwft_mode, 0, 0 = registered read (1-cycle latency), 1 = first-word-fall-through

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
cs  input  1  chip select; gates wr_en, rd_en, flush and clr_err
wr_en  input  1  write request
rd_en  input  1  read request (pop)
flush  input  1  synchronous clear of FIFO contents
clr_err  input  1  clears sticky error flags
data_in  input  data_width  write data
data_out  output  data_width  read data
empty  output  1  level == 0
full  output  1  level == fifo_depth
almost_empty  output  1  level <= almost_empty_th
almost_full  output  1  level >= almost_full_th
level  output  $clog2(fifo_depth)+1  current occupancy, 0..fifo_depth
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (asynchronous, immediate on rst rise; also valid mid-operation):
  - wr_ptr = rd_ptr = 0, level = 0, data_out = 0, overflow = underflow = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not reset.
- Pointers: log2(depth)+1 bits, with a wrap bit. Empty when the pointers are equal. Full when the index bits are equal and the wrap bits differ. level = wr_ptr - rd_ptr, computed modulo 2^(log2+1). All flags derive combinationally from the registered pointers.
- Accepted read (rd_ok) = cs & rd_en & !empty.
- Accepted write (wr_ok) = cs & wr_en & (!full | rd_ok).
  - Full with simultaneous read: both are accepted and level stays at fifo_depth.
  - Empty with simultaneous write: only the write is accepted. The read is rejected and flagged.
- Write: on wr_ok, mem[wr_ptr index] <= data_in and wr_ptr increments, wrapping naturally.
- Read, fwft_mode = 0:
  - On rd_ok, data_out <= mem[rd_ptr index] at the clock edge and rd_ptr increments.
  - Data is visible the cycle after rd_en.
  - data_out holds its value when there is no rd_ok.
- Read, fwft_mode = 1:
  - data_out = mem[rd_ptr index] combinationally. The head word is valid whenever empty = 0.
  - rd_ok advances rd_ptr.
  - A write into an empty FIFO makes data valid and deasserts empty one cycle after the write edge.
  - data_out is undefined/don't-care while empty, and equals 0 immediately after reset.
- Full-with-read pairing: the read returns the old head word. The write lands in the slot freed by that read, with no corruption.
- Flush: cs & flush sets wr_ptr = rd_ptr = 0 at the next edge.
  - Flush has priority over wr_en/rd_en in the same cycle; that write and read are ignored and not flagged.
  - data_out is unchanged in mode 0. Error flags are unchanged.
- Errors:
  - overflow sets on cs & wr_en & full & !rd_ok.
  - underflow sets on cs & rd_en & empty.
  - cs & clr_err clears both flags; a set event in the same cycle wins.
- Without cs, no state changes except asynchronous reset.

Test Plan:
- Reset then 8 writes of 0x11..0x88 (depth 8), no reads -> level steps 1..8. almost_full asserts on level 6. full asserts after the 8th edge. 9th write sets overflow, level stays 8.
- Mode 0: read 8 times -> data_out = 0x11..0x88, each one cycle after its rd_en. empty asserts after the 8th read. almost_empty asserts at level 2. Extra read sets underflow and data_out holds 0x88.
- Full FIFO, simultaneous wr 0xAA and rd for 1 cycle -> data_out = 0x11, level stays 8, no overflow. After draining, 0xAA emerges last.
- Mode 1: write 0x5A into empty FIFO -> empty = 0 and data_out = 0x5A on the next cycle before any rd_en. rd_en pops; empty = 1 the following cycle.
- Fill to level 5, assert flush together with wr_en -> level = 0 and empty = 1 next cycle, no overflow. Pointer wrap: 3 full fill/drain cycles preserve data order.
- Assert rst asynchronously mid-burst at level 4 with overflow set -> all outputs go to their reset values before the next clk edge. clr_err alone clears sticky flags.
